// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the decode-side hazard unit: writeback source codes
// and the shadow-slot layout {vld, wr, reg, src, ld}.
package hazard_unit_pkg;

  localparam int REG_W_DEF = 3;
  localparam int SEL_W_DEF = 2;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    SRC_ALU = 2'b00,
    SRC_PC  = 2'b01,
    SRC_IMM = 2'b10,
    SRC_MEM = 2'b11
  } reg_src_e;

  // vld + wr + ld flags plus register index and writeback source
  function automatic int slot_w(input int reg_w, input int sel_w);
    return 3 + reg_w + sel_w;
  endfunction

endpackage

// File: rtl/hazard_unit_haz_slot.sv
// One shadow-pipeline entry: a load-enabled register with synchronous clear
// (clear wins when enabled) and asynchronous active-low reset.
module hazard_unit_haz_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= clr ? '0 : d;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Decode-side hazard detection and forwarding control with a 2-deep shadow
// pipeline (X, M). Forwarding paths are built only when HAZARD_FWD_EN is defined.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_rs,
  input  logic [REG_W-1:0] dec_rt,
  input  logic             dec_rs_use,
  input  logic             dec_rt_use,
  input  logic             dec_regWrite,
  input  logic [REG_W-1:0] dec_writeReg,
  input  logic [SEL_W-1:0] dec_regSrc,
  input  logic             dec_memRead,
  input  logic             flush,
  input  logic             mem_stall,
  output logic             stall_fd,
  output logic             bubble_dx,
  output logic             FD_forward_XX_A,
  output logic             FD_forward_XX_B,
  output logic             FD_forward_XM_A,
  output logic             FD_forward_XM_B,
  output logic [SEL_W-1:0] FD_forward_XX_sel,
  output logic [SEL_W-1:0] FD_forward_XM_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int SLOT_W = slot_w(REG_W, SEL_W);

  logic [SLOT_W-1:0] issue_d;
  logic [SLOT_W-1:0] x_q;
  logic [SLOT_W-1:0] m_q;

  logic             x_vld, x_wr, x_ld;
  logic [REG_W-1:0] x_reg;
  logic [SEL_W-1:0] x_src;
  logic             m_vld, m_wr, m_ld;
  logic [REG_W-1:0] m_reg;
  logic [SEL_W-1:0] m_src;

  logic hit_x_rs, hit_x_rt, hit_m_rs, hit_m_rt;
  logic haz;

  assign issue_d = {dec_valid, dec_regWrite, dec_writeReg, dec_regSrc, dec_memRead};

  // X takes the issued entry (or a bubble), M takes old X; both freeze on mem_stall
  hazard_unit_haz_slot #(.W(SLOT_W)) u_slot_x (
    .clk   (clk),
    .rst_n (rst),
    .en    (~mem_stall),
    .clr   (bubble_dx),
    .d     (issue_d),
    .q     (x_q)
  );

  hazard_unit_haz_slot #(.W(SLOT_W)) u_slot_m (
    .clk   (clk),
    .rst_n (rst),
    .en    (~mem_stall),
    .clr   (1'b0),
    .d     (x_q),
    .q     (m_q)
  );

  assign {x_vld, x_wr, x_reg, x_src, x_ld} = x_q;
  assign {m_vld, m_wr, m_reg, m_src, m_ld} = m_q;

  assign hit_x_rs = x_vld & x_wr & (x_reg == dec_rs) & dec_rs_use;
  assign hit_x_rt = x_vld & x_wr & (x_reg == dec_rt) & dec_rt_use;
  assign hit_m_rs = m_vld & m_wr & (m_reg == dec_rs) & dec_rs_use;
  assign hit_m_rt = m_vld & m_wr & (m_reg == dec_rt) & dec_rt_use;

`ifdef HAZARD_FWD_EN
  logic fwd_ok;
  logic unused_fields;

  // only a load in X cannot be forwarded in time
  assign haz           = dec_valid & x_ld & (hit_x_rs | hit_x_rt);
  assign fwd_ok        = dec_valid & ~bubble_dx & ~flush;
  assign unused_fields = m_ld;

  always_comb begin
    FD_forward_XX_A   = 1'b0;
    FD_forward_XX_B   = 1'b0;
    FD_forward_XM_A   = 1'b0;
    FD_forward_XM_B   = 1'b0;
    FD_forward_XX_sel = '0;
    FD_forward_XM_sel = '0;
    if (fwd_ok) begin
      FD_forward_XX_A = hit_x_rs;
      FD_forward_XX_B = hit_x_rt;
      FD_forward_XM_A = hit_m_rs & ~hit_x_rs;
      FD_forward_XM_B = hit_m_rt & ~hit_x_rt;
      if (hit_x_rs | hit_x_rt) begin
        FD_forward_XX_sel = x_src;
      end
      if ((hit_m_rs & ~hit_x_rs) | (hit_m_rt & ~hit_x_rt)) begin
        FD_forward_XM_sel = m_src;
      end
    end
  end
`else
  logic unused_fields;

  // without bypass paths every in-flight producer must drain first
  assign haz               = dec_valid & (hit_x_rs | hit_x_rt | hit_m_rs | hit_m_rt);
  assign FD_forward_XX_A   = 1'b0;
  assign FD_forward_XX_B   = 1'b0;
  assign FD_forward_XM_A   = 1'b0;
  assign FD_forward_XM_B   = 1'b0;
  assign FD_forward_XX_sel = '0;
  assign FD_forward_XM_sel = '0;
  assign unused_fields     = ^{x_src, m_src, x_ld, m_ld};
`endif

  // mem_stall freezes everything (a pending flush waits), then flush, then RAW
  always_comb begin
    stall_fd  = 1'b0;
    bubble_dx = 1'b0;
    if (mem_stall) begin
      stall_fd = 1'b1;
    end else if (flush) begin
      bubble_dx = 1'b1;
    end else if (haz) begin
      stall_fd  = 1'b1;
      bubble_dx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_fd && !mem_stall && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed table, reset/saturation corners,
// and randomized traffic against an in-flight-list reference model.
module tb_hazard_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          dec_valid, dec_rs_use, dec_rt_use, dec_regWrite, dec_memRead;
  logic [2:0]    dec_rs, dec_rt, dec_writeReg;
  logic [1:0]    dec_regSrc;
  logic          flush, mem_stall;
  logic          stall_fd, bubble_dx;
  logic          xx_a, xx_b, xm_a, xm_b;
  logic [1:0]    xx_sel, xm_sel;
  logic [CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_unit #(.REG_W(3), .SEL_W(2), .CNT_W(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .dec_valid         (dec_valid),
    .dec_rs            (dec_rs),
    .dec_rt            (dec_rt),
    .dec_rs_use        (dec_rs_use),
    .dec_rt_use        (dec_rt_use),
    .dec_regWrite      (dec_regWrite),
    .dec_writeReg      (dec_writeReg),
    .dec_regSrc        (dec_regSrc),
    .dec_memRead       (dec_memRead),
    .flush             (flush),
    .mem_stall         (mem_stall),
    .stall_fd          (stall_fd),
    .bubble_dx         (bubble_dx),
    .FD_forward_XX_A   (xx_a),
    .FD_forward_XX_B   (xx_b),
    .FD_forward_XM_A   (xm_a),
    .FD_forward_XM_B   (xm_b),
    .FD_forward_XX_sel (xx_sel),
    .FD_forward_XM_sel (xm_sel),
    .stall_cnt         (stall_cnt)
  );

  typedef struct {
    logic       valid;
    logic [2:0] rs, rt;
    logic       rsu, rtu, wr;
    logic [2:0] wreg;
    logic [1:0] src;
    logic       ld, flush, ms;
  } vin_t;

  typedef struct {
    logic       stall, bub, xxa, xxb, xma, xmb;
    logic [1:0] xxs, xms;
    int         cnt;
  } vout_t;

  typedef struct {
    logic       vld, wr, ld;
    logic [2:0] rd;
    logic [1:0] src;
  } inflight_t;

  // youngest first; an empty position means nothing in flight there
  inflight_t flight[$];
  int        m_cnt;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  function automatic vin_t mi(input int v, rs, rt, rsu, rtu, wr, wreg, src, ld, fl, ms);
    vin_t r;
    r.valid = 1'(v);   r.rs  = 3'(rs);  r.rt  = 3'(rt);
    r.rsu   = 1'(rsu); r.rtu = 1'(rtu); r.wr  = 1'(wr);
    r.wreg  = 3'(wreg); r.src = 2'(src); r.ld = 1'(ld);
    r.flush = 1'(fl);  r.ms  = 1'(ms);
    return r;
  endfunction

  function automatic vout_t mo(input int st, bu, xa, xb, ma, mb, xs, ms, cnt);
    vout_t r;
    r.stall = 1'(st); r.bub = 1'(bu);
    r.xxa = 1'(xa); r.xxb = 1'(xb); r.xma = 1'(ma); r.xmb = 1'(mb);
    r.xxs = 2'(xs); r.xms = 2'(ms); r.cnt = cnt;
    return r;
  endfunction

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endfunction

  task automatic apply(input vin_t v);
    dec_valid = v.valid; dec_rs = v.rs; dec_rt = v.rt;
    dec_rs_use = v.rsu; dec_rt_use = v.rtu; dec_regWrite = v.wr;
    dec_writeReg = v.wreg; dec_regSrc = v.src; dec_memRead = v.ld;
    flush = v.flush; mem_stall = v.ms;
  endtask

  task automatic check_all(input vout_t e, input string tag);
    chk({tag, ".stall_fd"}, int'(stall_fd), int'(e.stall));
    chk({tag, ".bubble_dx"}, int'(bubble_dx), int'(e.bub));
    chk({tag, ".xx_a"}, int'(xx_a), int'(e.xxa));
    chk({tag, ".xx_b"}, int'(xx_b), int'(e.xxb));
    chk({tag, ".xm_a"}, int'(xm_a), int'(e.xma));
    chk({tag, ".xm_b"}, int'(xm_b), int'(e.xmb));
    chk({tag, ".xx_sel"}, int'(xx_sel), int'(e.xxs));
    chk({tag, ".xm_sel"}, int'(xm_sel), int'(e.xms));
    chk({tag, ".stall_cnt"}, int'(stall_cnt), e.cnt);
  endtask

  // youngest in-flight producer of r, or -1
  function automatic int producer_age(input logic [2:0] r, input logic use_r);
    for (int i = 0; i < flight.size(); i++)
      if (use_r && flight[i].vld && flight[i].wr && flight[i].rd == r) return i;
    return -1;
  endfunction

  function automatic vout_t model_eval(input vin_t v);
    vout_t e;
    int    a_rs, a_rt;
    bit    haz;
    e = mo(0, 0, 0, 0, 0, 0, 0, 0, m_cnt);
    a_rs = producer_age(v.rs, v.rsu);
    a_rt = producer_age(v.rt, v.rtu);
    if (FWD) haz = v.valid && ((a_rs == 0 || a_rt == 0) && flight[0].ld);
    else     haz = v.valid && (a_rs >= 0 || a_rt >= 0);
    if (v.ms)         e.stall = 1;
    else if (v.flush) e.bub = 1;
    else if (haz)     begin e.stall = 1; e.bub = 1; end
    if (FWD && v.valid && !e.bub && !v.flush) begin
      e.xxa = (a_rs == 0); e.xxb = (a_rt == 0);
      e.xma = (a_rs == 1); e.xmb = (a_rt == 1);
      if (e.xxa || e.xxb) e.xxs = flight[0].src;
      if (e.xma || e.xmb) e.xms = flight[1].src;
    end
    return e;
  endfunction

  task automatic model_adv(input vin_t v, input vout_t e);
    inflight_t n;
    if (v.ms) return;
    n.vld = v.valid && !e.bub; n.wr = v.wr; n.ld = v.ld; n.rd = v.wreg; n.src = v.src;
    flight.push_front(n);
    if (flight.size() > 2) void'(flight.pop_back());
    if (e.stall && !v.flush && m_cnt < (1 << CW) - 1) m_cnt++;
  endtask

  task automatic mstep(input vin_t v, input string tag);
    vout_t e;
    @(negedge clk);
    apply(v);
    #1;
    e = model_eval(v);
    check_all(e, tag);
    model_adv(v, e);
  endtask

  vin_t  tin[24];
  vout_t tout[24];

  initial begin
    rst = 1'b0;
    apply(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    #1;
    check_all(mo(0, 0, 0, 0, 0, 0, 0, 0, 0), "reset");
    @(negedge clk);
    rst = 1'b1;

    tin[0]  = mi(1, 2, 3, 1, 1, 1, 1, 0, 0, 0, 0);
    tin[1]  = mi(1, 1, 3, 1, 1, 1, 2, 0, 0, 0, 0);
    tin[2]  = tin[1];
    tin[3]  = tin[1];
    tin[4]  = mi(1, 5, 0, 1, 0, 1, 4, 3, 1, 0, 0);
    tin[5]  = mi(1, 4, 4, 1, 1, 1, 5, 0, 0, 0, 0);
    tin[6]  = mi(1, 4, 4, 1, 1, 1, 5, 0, 0, 0, 1);
    tin[7]  = tin[6];
    tin[8]  = tin[6];
    tin[9]  = tin[5];
    tin[10] = tin[5];
    tin[11] = mi(1, 3, 0, 1, 0, 1, 2, 3, 1, 0, 0);
    tin[12] = mi(1, 2, 2, 1, 1, 1, 6, 0, 0, 1, 0);
    tin[13] = mi(0, 2, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    tin[14] = mi(1, 2, 0, 1, 0, 1, 3, 0, 0, 1, 1);
    tin[15] = mi(1, 2, 0, 1, 0, 1, 3, 0, 0, 1, 0);
    tin[16] = mi(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0);
    tin[17] = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tin[18] = mi(1, 7, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    tin[19] = tin[18];
    tin[20] = mi(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    tin[21] = mi(1, 0, 0, 1, 1, 1, 3, 0, 0, 0, 0);
    tin[22] = tin[21];
    tin[23] = tin[21];
`ifdef HAZARD_FWD_EN
    tout[0]  = mo(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tout[1]  = mo(0, 0, 1, 0, 0, 0, 0, 0, 0);
    tout[2]  = mo(0, 0, 0, 0, 1, 0, 0, 0, 0);
    tout[3]  = mo(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tout[4]  = mo(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tout[5]  = mo(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tout[6]  = mo(1, 0, 0, 0, 1, 1, 0, 3, 1);
    tout[7]  = tout[6];
    tout[8]  = tout[6];
    tout[9]  = mo(0, 0, 0, 0, 1, 1, 0, 3, 1);
    tout[10] = mo(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tout[11] = mo(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tout[12] = mo(0, 1, 0, 0, 0, 0, 0, 0, 1);
    tout[13] = mo(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tout[14] = mo(1, 0, 0, 0, 0, 0, 0, 0, 1);
    tout[15] = mo(0, 1, 0, 0, 0, 0, 0, 0, 1);
    tout[16] = mo(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tout[17] = mo(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tout[18] = mo(0, 0, 0, 0, 1, 0, 0, 1, 1);
    tout[19] = mo(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tout[20] = mo(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tout[21] = mo(0, 0, 1, 1, 0, 0, 0, 0, 1);
    tout[22] = mo(0, 0, 0, 0, 1, 1, 0, 0, 1);
    tout[23] = mo(0, 0, 0, 0, 0, 0, 0, 0, 1);
`else
    tout[0]  = mo(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tout[1]  = mo(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tout[2]  = mo(1, 1, 0, 0, 0, 0, 0, 0, 1);
    tout[3]  = mo(0, 0, 0, 0, 0, 0, 0, 0, 2);
    tout[4]  = mo(0, 0, 0, 0, 0, 0, 0, 0, 2);
    tout[5]  = mo(1, 1, 0, 0, 0, 0, 0, 0, 2);
    tout[6]  = mo(1, 0, 0, 0, 0, 0, 0, 0, 3);
    tout[7]  = tout[6];
    tout[8]  = tout[6];
    tout[9]  = mo(1, 1, 0, 0, 0, 0, 0, 0, 3);
    tout[10] = mo(0, 0, 0, 0, 0, 0, 0, 0, 4);
    tout[11] = mo(0, 0, 0, 0, 0, 0, 0, 0, 4);
    tout[12] = mo(0, 1, 0, 0, 0, 0, 0, 0, 4);
    tout[13] = mo(0, 0, 0, 0, 0, 0, 0, 0, 4);
    tout[14] = mo(1, 0, 0, 0, 0, 0, 0, 0, 4);
    tout[15] = mo(0, 1, 0, 0, 0, 0, 0, 0, 4);
    tout[16] = mo(0, 0, 0, 0, 0, 0, 0, 0, 4);
    tout[17] = mo(0, 0, 0, 0, 0, 0, 0, 0, 4);
    tout[18] = mo(1, 1, 0, 0, 0, 0, 0, 0, 4);
    tout[19] = mo(0, 0, 0, 0, 0, 0, 0, 0, 5);
    tout[20] = mo(0, 0, 0, 0, 0, 0, 0, 0, 5);
    tout[21] = mo(1, 1, 0, 0, 0, 0, 0, 0, 5);
    tout[22] = mo(1, 1, 0, 0, 0, 0, 0, 0, 6);
    tout[23] = mo(0, 0, 0, 0, 0, 0, 0, 0, 7);
`endif

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      apply(tin[i]);
      #1;
      check_all(tout[i], $sformatf("vec%0d", i));
    end

    // asynchronous reset while a load-use hazard is being flagged
    @(negedge clk);
    apply(mi(1, 5, 0, 1, 0, 1, 6, 3, 1, 0, 0));
    @(negedge clk);
    apply(mi(1, 6, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    #1;
    chk("rst_mid.pre_stall", int'(stall_fd), 1);
    chk("rst_mid.pre_bubble", int'(bubble_dx), 1);
    #1;
    rst = 1'b0;
    #1;
    check_all(mo(0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_mid");
    flight.delete();
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    mstep(mi(1, 6, 0, 1, 0, 1, 1, 0, 0, 0, 0), "rst_release");

    // drive the stall counter into saturation
    for (int k = 0; k < 20; k++) begin
      mstep(mi(1, 2, 0, 1, 0, 1, 1, 3, 1, 0, 0), "sat_ld");
      for (int j = 0; j < 3; j++)
        mstep(mi(1, 1, 1, 1, 1, 1, 3, 0, 0, 0, 0), "sat_use");
    end
    @(negedge clk);
    apply(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("sat.stall_cnt", int'(stall_cnt), (1 << CW) - 1);
    model_adv(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // randomized traffic, with a reset so the counter is exercised from zero again
    @(negedge clk);
    rst = 1'b0;
    flight.delete();
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      vin_t v;
      v.valid = ($urandom_range(0, 7) != 0);
      v.rs    = 3'($urandom_range(0, 7));
      v.rt    = 3'($urandom_range(0, 7));
      v.rsu   = 1'($urandom_range(0, 1));
      v.rtu   = 1'($urandom_range(0, 1));
      v.wr    = ($urandom_range(0, 3) != 0);
      v.wreg  = 3'($urandom_range(0, 7));
      v.src   = 2'($urandom_range(0, 3));
      v.ld    = ($urandom_range(0, 2) == 0);
      v.flush = ($urandom_range(0, 7) == 0);
      v.ms    = ($urandom_range(0, 7) == 0);
      mstep(v, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
